// File: rtl/wb_line_memory.sv
// Wishbone slave modelling line-organised main memory behind the cache.
// Each accepted request is serviced after LATENCY cycles with a single-cycle ACK.
module wb_line_memory #(
  parameter int unsigned LATENCY       = 4,
  parameter int unsigned LINE_IDX_BITS = 12,
  parameter string       INIT_FILE     = ""
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         CYC,
  input  logic         STB,
  input  logic         WE,
  input  logic [15:0]  ADR,
  input  logic [127:0] DAT_M,
  output logic [127:0] DAT_S,
  output logic         ACK
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic                     we_q, we_d;
  logic [LINE_IDX_BITS-1:0] idx_q, idx_d;
  logic [127:0]             wdata_q, wdata_d;

  logic [127:0] mem [0:(1<<LINE_IDX_BITS)-1];

  // Low nibble and any index bits above LINE_IDX_BITS deliberately play no role.
  logic unused_adr;
  assign unused_adr = ^ADR;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (CYC && STB) begin
          we_d    = WE;
          idx_d   = ADR[4 +: LINE_IDX_BITS];
          wdata_d = DAT_M;
          cnt_d   = 4'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Master abandoning the cycle wins over an expiring counter.
        if (!CYC) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  // Write commits at the edge ending RESP, so a following read sees it.
  always_ff @(posedge clk) begin
    if (!rst && state_q == RESP && we_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign ACK   = (state_q == RESP);
  assign DAT_S = (state_q == RESP && !we_q) ? mem[idx_q] : '0;

  ack_single_cycle: assert property (@(posedge clk) disable iff (rst) ACK |=> !ACK);

endmodule

// File: tb/tb_wb_line_memory.sv
// Self-checking bench for wb_line_memory: four instances with different latency and
// index width, table-driven transfers, a scoreboard of expected ACKs and corner sequences.
module tb_wb_line_memory;

  localparam logic [127:0] DEAD = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0011_2233;
  localparam logic [127:0] P5   = 128'h5555_0000_5555_0000_5555_0000_5555_0005;
  localparam logic [127:0] Z8   = 128'h8888_1234_8888_1234_8888_1234_8888_0008;
  localparam logic [127:0] A1   = 128'hA1A1_0101_A1A1_0101_A1A1_0101_A1A1_0101;
  localparam logic [127:0] B2   = 128'hB2B2_0202_B2B2_0202_B2B2_0202_B2B2_0202;
  localparam logic [127:0] C3   = 128'hC3C3_0303_C3C3_0303_C3C3_0303_C3C3_0303;
  localparam logic [127:0] X7   = 128'h7777_ABCD_7777_ABCD_7777_ABCD_7777_0007;
  localparam logic [127:0] YY   = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
  localparam logic [127:0] AA   = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
  localparam logic [127:0] W7   = 128'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   cyc, stb, we, ack;
  logic [15:0]  adr   [4];
  logic [127:0] dat_m [4];
  logic [127:0] dat_s [4];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int           dut;
    int           lat;
    logic [127:0] dat;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int           dut;
    logic         w;
    logic [15:0]  a;
    logic [127:0] d;
    logic [127:0] e;
    string        name;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  wb_line_memory #(.LATENCY(4)) u0 (
    .clk(clk), .rst(rst), .CYC(cyc[0]), .STB(stb[0]), .WE(we[0]),
    .ADR(adr[0]), .DAT_M(dat_m[0]), .DAT_S(dat_s[0]), .ACK(ack[0]));
  wb_line_memory #(.LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .CYC(cyc[1]), .STB(stb[1]), .WE(we[1]),
    .ADR(adr[1]), .DAT_M(dat_m[1]), .DAT_S(dat_s[1]), .ACK(ack[1]));
  wb_line_memory #(.LATENCY(2), .LINE_IDX_BITS(4)) u2 (
    .clk(clk), .rst(rst), .CYC(cyc[2]), .STB(stb[2]), .WE(we[2]),
    .ADR(adr[2]), .DAT_M(dat_m[2]), .DAT_S(dat_s[2]), .ACK(ack[2]));
  wb_line_memory #(.LATENCY(15)) u3 (
    .clk(clk), .rst(rst), .CYC(cyc[3]), .STB(stb[3]), .WE(we[3]),
    .ADR(adr[3]), .DAT_M(dat_m[3]), .DAT_S(dat_s[3]), .ACK(ack[3]));

  function automatic int lat_of(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      2:       return 2;
      default: return 15;
    endcase
  endfunction

  function automatic void cmp_val(input string name, input logic [127:0] act,
                                  input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, req);
    end
  endfunction

  // Callers are always at a negedge; the request is accepted at the following posedge.
  task automatic applyStimulus(input int d, input logic w, input logic [15:0] a,
                               input logic [127:0] dat, input logic [127:0] e);
    exp_t x;
    cyc[d]   = 1'b1;
    stb[d]   = 1'b1;
    we[d]    = w;
    adr[d]   = a;
    dat_m[d] = dat;
    x.dut = d;
    x.lat = lat_of(d);
    x.dat = e;
    exp_q.push_back(x);
    @(posedge clk);
    #1 stb[d] = 1'b0;
  endtask

  // Counts edges after acceptance until ACK, then checks data and pulse width.
  task automatic checkOutput(input string name);
    exp_t x;
    int   n;
    x = exp_q.pop_front();
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!ack[x.dut] && n < 40);
    cmp_val({name, "_lat"}, 128'(n), 128'(x.lat));
    cmp_val({name, "_dat"}, dat_s[x.dut], x.dat);
    @(posedge clk);
    @(negedge clk);
    cmp_val({name, "_ack1"}, {127'd0, ack[x.dut]}, 128'd0);
  endtask

  task automatic count_acks(input int d, input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ack[d]) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   n;
    exp_t x;

    vecs[0] = '{0, 1'b1, 16'h0120, DEAD, 128'd0, "wr_0120"};
    vecs[1] = '{0, 1'b0, 16'h012E, 128'd0, DEAD, "rd_012E"};
    vecs[2] = '{0, 1'b1, 16'h0050, P5, 128'd0, "wr_line5"};
    vecs[3] = '{0, 1'b1, 16'h0080, Z8, 128'd0, "wr_line8"};
    vecs[4] = '{1, 1'b1, 16'h0050, A1, 128'd0, "l1_wr"};
    vecs[5] = '{1, 1'b0, 16'h0058, 128'd0, A1, "l1_rd"};
    vecs[6] = '{2, 1'b1, 16'h0030, B2, 128'd0, "l2_wr"};
    vecs[7] = '{2, 1'b0, 16'h0130, 128'd0, B2, "l2_rd_alias"};
    vecs[8] = '{3, 1'b1, 16'h0200, C3, 128'd0, "l15_wr"};
    vecs[9] = '{3, 1'b0, 16'h020F, 128'd0, C3, "l15_rd"};

    cyc = '0;
    stb = '0;
    we  = '0;
    for (int i = 0; i < 4; i++) begin
      adr[i]   = '0;
      dat_m[i] = '0;
    end

    // Request held through reset must not be seen until reset releases.
    rst      = 1'b1;
    cyc[0]   = 1'b1;
    stb[0]   = 1'b1;
    we[0]    = 1'b1;
    dat_m[0] = 128'h1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      cmp_val($sformatf("rst_ack%0d", i), {127'd0, ack[0]}, 128'd0);
      cmp_val($sformatf("rst_dat%0d", i), dat_s[0], 128'd0);
    end
    rst = 1'b0;
    x.dut = 0;
    x.lat = 4;
    x.dat = 128'd0;
    exp_q.push_back(x);
    @(posedge clk);
    #1 stb[0] = 1'b0;
    checkOutput("rst_release");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].dut, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].e);
      checkOutput(vecs[i].name);
    end

    // Abort: CYC drops during the second BUSY cycle of a write to line 5.
    cyc[0]   = 1'b1;
    stb[0]   = 1'b1;
    we[0]    = 1'b1;
    adr[0]   = 16'h0050;
    dat_m[0] = AA;
    @(posedge clk);
    #1 stb[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc[0] = 1'b0;
    count_acks(0, 20, n);
    cmp_val("abort_no_ack", 128'(n), 128'd0);
    applyStimulus(0, 1'b0, 16'h0050, 128'd0, P5);
    checkOutput("abort_rd");

    // STB held through the ACK cycle, then a fresh back-to-back request.
    cyc[0] = 1'b1;
    stb[0] = 1'b1;
    we[0]  = 1'b0;
    adr[0] = 16'h0080;
    x.dut = 0;
    x.lat = 4;
    x.dat = Z8;
    exp_q.push_back(x);
    @(posedge clk);
    checkOutput("stb_hold");
    applyStimulus(0, 1'b0, 16'h0123, 128'd0, DEAD);
    checkOutput("b2b_rd");

    // Request fields change while BUSY; the latched write must win.
    cyc[0]   = 1'b1;
    stb[0]   = 1'b1;
    we[0]    = 1'b1;
    adr[0]   = 16'h0070;
    dat_m[0] = X7;
    x.dut = 0;
    x.lat = 4;
    x.dat = 128'd0;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    stb[0]   = 1'b0;
    we[0]    = 1'b0;
    adr[0]   = 16'h0080;
    dat_m[0] = YY;
    checkOutput("fld_wr");
    applyStimulus(0, 1'b0, 16'h0070, 128'd0, X7);
    checkOutput("fld_rd7");
    applyStimulus(0, 1'b0, 16'h0080, 128'd0, Z8);
    checkOutput("fld_rd8");

    // Reset while a write to line 7 is in BUSY.
    cyc[0]   = 1'b1;
    stb[0]   = 1'b1;
    we[0]    = 1'b1;
    adr[0]   = 16'h0070;
    dat_m[0] = W7;
    @(posedge clk);
    #1 stb[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    cyc[0] = 1'b0;
    count_acks(0, 20, n);
    cmp_val("rstmid_no_ack", 128'(n), 128'd0);
    applyStimulus(0, 1'b0, 16'h0070, 128'd0, X7);
    checkOutput("rstmid_rd");

    // STB without CYC, then CYC without STB: both must stay idle.
    cyc[1] = 1'b0;
    stb[1] = 1'b1;
    count_acks(1, 8, n);
    cmp_val("stb_only", 128'(n), 128'd0);
    cyc[1] = 1'b1;
    stb[1] = 1'b0;
    count_acks(1, 8, n);
    cmp_val("cyc_only", 128'(n), 128'd0);
    cyc = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
